// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter with bounded lock bursts for single-port dmem (DMEM_ARB_FIXED_PRIO_EN selects fixed priority)
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_lock,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_lock,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_LOCK);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] lock_cnt, cnt_nx, base;
    logic          gnt, sel, idle_sel, cont, lock;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign idle_sel = ~r0_req;
`else
    logic last_gnt;
    assign idle_sel = (r0_req & r1_req) ? ~last_gnt : ~r0_req;
`endif

    // winner selection (owner keeps grant unless its burst hit the bound) and next burst state
    always_comb begin
        gnt      = (r0_req | r1_req) & ~reset;
        sel      = (state == OWN0 && r0_req) ? (lock_cnt == MAXC && r1_req) :
                   (state == OWN1 && r1_req) ? !(lock_cnt == MAXC && r0_req) : idle_sel;
        cont     = (state == OWN0 && !sel) || (state == OWN1 && sel);
        base     = cont ? lock_cnt : '0;
        lock     = sel ? r1_lock : r0_lock;
        state_nx = (gnt && lock && base < MAXC) ? (sel ? OWN1 : OWN0) : IDLE;
        cnt_nx   = (gnt && lock && base < MAXC) ? base + CW'(1) : '0;
    end

    assign r0_gnt = gnt & ~sel;
    assign r1_gnt = gnt & sel;
    assign mem_we = gnt & (sel ? r1_we : r0_we);
    assign mem_a  = sel ? r1_addr : r0_addr;
    assign mem_wd = sel ? r1_wdata : r0_wdata;

    // ownership state, burst length and round-robin history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lock_cnt <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            state    <= state_nx;
            lock_cnt <= cnt_nx;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            if (gnt) last_gnt <= sel;
`endif
        end
    end

    // capture read data for the read winner; valid pulses for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            r0_rvalid <= r0_gnt & ~r0_we;
            r1_rvalid <= r1_gnt & ~r1_we;
            if (r0_gnt & ~r0_we) r0_rdata <= mem_rd;
            if (r1_gnt & ~r1_we) r1_rdata <= mem_rd;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter with a small behavioural dmem
module tb_dmem_arbiter;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        r0_req, r0_lock, r0_we, r1_req, r1_lock, r1_we;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, mem_we;
    logic [31:0] r0_rdata, r1_rdata, mem_a, mem_wd, mem_rd;
    logic [31:0] mem [0:15];
    int          tests = 0, fails = 0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_a[5:2]] <= mem_wd;
    assign mem_rd = mem[mem_a[5:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000 + i;
        r0_req = 1'b1; r0_lock = 1'b0; r0_we = 1'b1; r0_addr = 32'h13; r0_wdata = 32'hDEADBEEF;
        r1_req = 1'b1; r1_lock = 1'b0; r1_we = 1'b0; r1_addr = 32'h10; r1_wdata = 32'h0;
        #2;
        chk("rst_r0_gnt", r0_gnt, 0);
        chk("rst_r1_gnt", r1_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        tick();
        chk("rst_r0_rvalid", r0_rvalid, 0);
        chk("rst_r1_rvalid", r1_rvalid, 0);
        chk("rst_r0_rdata", r0_rdata, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("first_r0_gnt", r0_gnt, 1);
        chk("first_r1_gnt", r1_gnt, 0);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_a_unaligned", mem_a, 32'h13);
        chk("wr_mem_wd", mem_wd, 32'hDEADBEEF);
        tick();
        chk("wr_no_rvalid", r0_rvalid, 0);
        r0_req = 1'b0; r0_we = 1'b0;
        #1;
        chk("raw_r1_gnt", r1_gnt, 1);
        chk("raw_mem_we", mem_we, 0);
        chk("raw_mem_a", mem_a, 32'h10);
        tick();
        chk("raw_r1_rvalid", r1_rvalid, 1);
        chk("raw_r1_rdata", r1_rdata, 32'hDEADBEEF);
        r0_req = 1'b1; r0_addr = 32'h20; r1_addr = 32'h24;
        #1;
        chk("alt0_r0_gnt", r0_gnt, 1);
        tick();
        chk("alt0_r0_rvalid", r0_rvalid, 1);
        chk("alt0_r0_rdata", r0_rdata, 32'h1008);
        chk("alt0_r1_rvalid", r1_rvalid, 0);
        chk("alt0_r1_rdata_hold", r1_rdata, 32'hDEADBEEF);
        #1;
        chk("alt1_r1_gnt", r1_gnt, {31'b0, !FP});
        chk("alt1_r0_gnt", r0_gnt, {31'b0, FP});
        tick();
        chk("alt1_r1_rvalid", r1_rvalid, {31'b0, !FP});
        #1;
        chk("alt2_r0_gnt", r0_gnt, 1);
        tick();
        #1;
        chk("alt3_r1_gnt", r1_gnt, {31'b0, !FP});
        tick();
        r0_lock = 1'b1;
        #1;
        chk("lock_g0_r0_gnt", r0_gnt, 1);
        for (int k = 1; k < 4; k++) begin
            tick();
            #1;
            chk("lock_r0_gnt", r0_gnt, 1);
            chk("lock_r1_gnt", r1_gnt, 0);
        end
        tick();
        chk("lock_last_r0_rvalid", r0_rvalid, 1);
        #1;
        chk("lock_break_r1_gnt", r1_gnt, 1);
        chk("lock_break_r0_gnt", r0_gnt, 0);
        tick();
        chk("lock_break_r1_rvalid", r1_rvalid, 1);
        chk("lock_break_r1_rdata", r1_rdata, 32'h1009);
        r0_lock = 1'b0;
        #1;
        chk("after_break_r0_gnt", r0_gnt, 1);
        tick();
        r0_req = 1'b0; r1_addr = 32'h28; r1_lock = 1'b1;
        #1;
        chk("pre_rst_r1_gnt", r1_gnt, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_r1_gnt", r1_gnt, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        tick();
        chk("mid_rst_r1_rvalid", r1_rvalid, 0);
        chk("mid_rst_r1_rdata", r1_rdata, 0);
        chk("mid_rst_r0_rdata", r0_rdata, 0);
        reset = 1'b0; r0_req = 1'b1; r1_lock = 1'b0;
        #1;
        chk("post_rst_r0_gnt", r0_gnt, 1);
        chk("post_rst_r1_gnt", r1_gnt, 0);
        tick();
        chk("post_rst_r0_rvalid", r0_rvalid, 1);
        chk("post_rst_r0_rdata", r0_rdata, 32'h1008);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
